uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, 2-flop input synchronizer.
// Reports each frame with a one-cycle o_rx_done plus a stop-bit error flag.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done,
    output logic            o_frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            rx_meta_q, rx_s_q;

    // Synchronizer resets to the idle-high level so reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            // Edge detection is not gated by i_tick so the start is seen as early as possible.
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = (b_q >> 1) | (DBIT'(rx_s_q) << (DBIT - 1));
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        data_d  = b_q;
                        err_d   = ~rx_s_q;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_frame_err = err_q;
    assign o_rx_done   = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: the line is described as a list of 64-clock bit slots and an
// ideal-UART decoder over that list predicts the frames the receiver must report.
module tb_uart_rx;

    localparam int LO  = 0;
    localparam int HI  = 1;
    localparam int BAD = 2;  // low stop bit: low past mid-bit, then high for the last 16 clocks

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } frame_t;

    logic       clk;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int     slot_q[$];
    frame_t exp_q[$];
    frame_t got_q[$];
    int     checks;
    int     passed;
    int     double_done;
    int     unstable;
    logic [7:0] exp_data;
    logic       exp_err;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        i_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
        end
    end

    // Records every reported frame and watches the pulse and hold rules between reports.
    initial begin
        logic       prev_done;
        logic [7:0] prev_data;
        logic       prev_err;
        prev_done = 1'b0;
        prev_data = 8'h00;
        prev_err  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (i_reset) begin
                prev_done = 1'b0;
            end else if (o_rx_done) begin
                if (prev_done) double_done++;
                got_q.push_back('{err: o_frame_err, data: o_data});
                prev_done = 1'b1;
            end else begin
                if (o_data !== prev_data || o_frame_err !== prev_err) unstable++;
                prev_done = 1'b0;
            end
            prev_data = o_data;
            prev_err  = o_frame_err;
        end
    end

    task automatic add_frame(input logic [7:0] d, input bit good_stop);
        slot_q.push_back(LO);
        for (int k = 0; k < 8; k++) slot_q.push_back(d[k] ? HI : LO);
        slot_q.push_back(good_stop ? HI : BAD);
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) slot_q.push_back(HI);
    endtask

    task automatic drive_slot(input int idx);
        case (slot_q[idx])
            LO: begin
                i_rx = 1'b0;
                repeat (64) @(negedge clk);
            end
            HI: begin
                i_rx = 1'b1;
                repeat (64) @(negedge clk);
            end
            default: begin
                i_rx = 1'b0;
                repeat (48) @(negedge clk);
                i_rx = 1'b1;
                repeat (16) @(negedge clk);
            end
        endcase
    endtask

    task automatic drive_range(input int from, input int upto);
        for (int i = from; i < upto; i++) drive_slot(i);
    endtask

    // Ideal receiver: hunt for a low slot, take 8 data slots LSB first, then the stop slot.
    task automatic model_decode(input int from);
        int         i;
        logic [7:0] d;
        exp_q.delete();
        i = from;
        while (i + 9 < slot_q.size()) begin
            if (slot_q[i] == HI) begin
                i++;
            end else begin
                for (int k = 0; k < 8; k++) d[k] = (slot_q[i + 1 + k] == HI);
                exp_q.push_back('{err: (slot_q[i + 9] != HI), data: d});
                i += 10;
            end
        end
        if (exp_q.size() > 0) begin
            exp_data = exp_q[exp_q.size() - 1].data;
            exp_err  = exp_q[exp_q.size() - 1].err;
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (o_data !== 8'h00) $display("FAIL reset_data: got %02h required 00", o_data);
        else passed++;
        checks++;
        if (o_rx_done !== 1'b0) $display("FAIL reset_done: got %b required 0", o_rx_done);
        else passed++;
        checks++;
        if (o_frame_err !== 1'b0) $display("FAIL reset_err: got %b required 0", o_frame_err);
        else passed++;
        i_reset = 1'b0;
        exp_data = 8'h00;
        exp_err  = 1'b0;
        repeat (70) @(negedge clk);
    endtask

    task automatic test_single_a5;
        slot_q.delete();
        got_q.delete();
        add_idle(1);
        add_frame(8'hA5, 1'b1);
        add_idle(2);
        drive_range(0, slot_q.size());
        model_decode(0);
        checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL a5_count: got %0d frames required %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            $display("a5 frame %0d: data=%02h err=%0b", k, got_q[k].data, got_q[k].err);
            checks++;
            if (got_q[k] !== exp_q[k])
                $display("FAIL a5_frame: got %02h/%0b required %02h/%0b",
                         got_q[k].data, got_q[k].err, exp_q[k].data, exp_q[k].err);
            else passed++;
        end
    endtask

    task automatic test_random_frames;
        bit good;
        slot_q.delete();
        got_q.delete();
        for (int f = 0; f < 8; f++) begin
            good = ($urandom_range(0, 3) != 0);
            add_frame(8'($urandom), good);
            add_idle(good ? $urandom_range(0, 2) : $urandom_range(1, 2));
        end
        add_idle(2);
        drive_range(0, slot_q.size());
        model_decode(0);
        checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL random_count: got %0d frames required %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            $display("random frame %0d: data=%02h err=%0b", k, got_q[k].data, got_q[k].err);
            checks++;
            if (got_q[k] !== exp_q[k])
                $display("FAIL random_frame%0d: got %02h/%0b required %02h/%0b", k,
                         got_q[k].data, got_q[k].err, exp_q[k].data, exp_q[k].err);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        slot_q.delete();
        got_q.delete();
        add_frame(8'h00, 1'b1);
        add_frame(8'hFF, 1'b1);
        for (int f = 0; f < 4; f++) add_frame(8'($urandom), 1'b1);
        add_idle(2);
        drive_range(0, slot_q.size());
        model_decode(0);
        checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL b2b_count: got %0d frames required %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            $display("b2b frame %0d: data=%02h err=%0b", k, got_q[k].data, got_q[k].err);
            checks++;
            if (got_q[k] !== exp_q[k])
                $display("FAIL b2b_frame%0d: got %02h/%0b required %02h/%0b", k,
                         got_q[k].data, got_q[k].err, exp_q[k].data, exp_q[k].err);
            else passed++;
        end
    endtask

    task automatic test_glitch;
        got_q.delete();
        i_rx = 1'b0;
        repeat (20) @(negedge clk);
        i_rx = 1'b1;
        repeat (192) @(negedge clk);
        $display("glitch: frames reported=%0d", got_q.size());
        checks++;
        if (got_q.size() !== 0) $display("FAIL glitch_done: got %0d frames required 0", got_q.size());
        else passed++;
        checks++;
        if (o_data !== exp_data) $display("FAIL glitch_data: got %02h required %02h", o_data, exp_data);
        else passed++;
        // A clean frame straight after proves the receiver went back to hunting.
        slot_q.delete();
        add_frame(8'h42, 1'b1);
        add_idle(2);
        drive_range(0, slot_q.size());
        model_decode(0);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0])
            $display("FAIL glitch_recover: got %0d frames (first %02h) required 1 frame %02h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].data : 8'h00, exp_q[0].data);
        else passed++;
    endtask

    task automatic test_frame_error;
        slot_q.delete();
        got_q.delete();
        add_frame(8'h3C, 1'b0);
        add_idle(1);
        add_frame(8'h11, 1'b1);
        add_idle(2);
        drive_range(0, slot_q.size());
        model_decode(0);
        checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL ferr_count: got %0d frames required %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            $display("ferr frame %0d: data=%02h err=%0b", k, got_q[k].data, got_q[k].err);
            checks++;
            if (got_q[k] !== exp_q[k])
                $display("FAIL ferr_frame%0d: got %02h/%0b required %02h/%0b", k,
                         got_q[k].data, got_q[k].err, exp_q[k].data, exp_q[k].err);
            else passed++;
        end
        checks++;
        if (o_frame_err !== exp_err) $display("FAIL ferr_hold: got %b required %b", o_frame_err, exp_err);
        else passed++;
    endtask

    // The 0x5A frame is cut after its 4th data bit; the receiver then legitimately
    // resynchronises on the next falling edge inside the remaining bits.
    task automatic test_reset_mid_frame;
        slot_q.delete();
        got_q.delete();
        add_frame(8'h5A, 1'b1);
        add_idle(8);
        add_frame(8'h81, 1'b1);
        add_idle(2);
        drive_range(0, 5);
        i_rx    = (slot_q[5] == HI);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        repeat (63) @(negedge clk);
        drive_range(6, slot_q.size());
        model_decode(5);
        checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL rstmid_count: got %0d frames required %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            $display("rstmid frame %0d: data=%02h err=%0b", k, got_q[k].data, got_q[k].err);
            checks++;
            if (got_q[k] !== exp_q[k])
                $display("FAIL rstmid_frame%0d: got %02h/%0b required %02h/%0b", k,
                         got_q[k].data, got_q[k].err, exp_q[k].data, exp_q[k].err);
            else passed++;
        end
        checks++;
        if (o_data !== 8'h81) $display("FAIL rstmid_last: got %02h required 81", o_data);
        else passed++;
    endtask

    task automatic test_reset_after_frame;
        i_rx    = 1'b1;
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        $display("reset after frame: data=%02h err=%0b done=%0b", o_data, o_frame_err, o_rx_done);
        checks++;
        if (o_data !== 8'h00) $display("FAIL rstpost_data: got %02h required 00", o_data);
        else passed++;
        checks++;
        if (o_frame_err !== 1'b0) $display("FAIL rstpost_err: got %b required 0", o_frame_err);
        else passed++;
        checks++;
        if (o_rx_done !== 1'b0) $display("FAIL rstpost_done: got %b required 0", o_rx_done);
        else passed++;
        exp_data = 8'h00;
        exp_err  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_output_rules;
        checks++;
        if (double_done !== 0) $display("FAIL done_width: got %0d double pulses required 0", double_done);
        else passed++;
        checks++;
        if (unstable !== 0) $display("FAIL output_hold: got %0d changes outside done required 0", unstable);
        else passed++;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        double_done = 0;
        unstable    = 0;
        i_reset     = 1'b1;
        i_rx        = 1'b1;
        @(negedge clk);
        test_reset;
        test_single_a5;
        test_random_frames;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        test_reset_after_frame;
        test_output_rules;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
